lifo_drain_ctrl: RTL and testbench

Pop-side controller for the 8-deep stack buffer. On a start request it pops up to a programmed number of entries, stopping early if the stack runs empty. Each popped word is captured and presented on a valid/ready output stream; a one-cycle done pulse and a short flag end the run. It sits between the stack's pop/empty/dout pins and a downstream consumer.

---
 rtl/lifo_drain_if.sv | 31 +++
 rtl/lifo_drain_ctrl.sv | 106 ++++++++++
 tb/tb_lifo_drain_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lifo_drain_if.sv
// Handshake bundle between the LIFO drain controller, the stack pop port,
// the run-control side and the downstream stream consumer.
interface lifo_drain_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             done;
    logic             short;
    logic [CNT_W-1:0] count;
    logic             lifo_pop;
    logic             lifo_empty;
    logic [WIDTH-1:0] lifo_dout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Controller side
    modport slave (
        input  start, len, lifo_empty, lifo_dout, out_ready,
        output busy, done, short, count, lifo_pop, out_valid, out_data
    );

    // Environment side: run control, stack and consumer
    modport master (
        output start, len, lifo_empty, lifo_dout, out_ready,
        input  busy, done, short, count, lifo_pop, out_valid, out_data
    );
endinterface

// File: rtl/lifo_drain_ctrl.sv
// Pop-side controller for the 8-deep stack: drains up to len entries onto a
// valid/ready stream, stopping early on empty, with a done pulse and short flag.
module lifo_drain_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rstn,
    lifo_drain_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             short_q, short_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        short_d     = short_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.len;
                    count_d     = CNT_ZERO;
                    short_d     = 1'b0;
                    state_d     = (bus.len == CNT_ZERO) ? S_DONE : S_POP;
                end
            end
            S_POP: begin
                if (bus.lifo_empty) begin
                    short_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    remaining_d = remaining_q - CNT_ONE;
                    state_d     = S_CAPT;
                end
            end
            S_CAPT: begin
                // Stack read data is valid the cycle after the pop strobe
                out_data_d  = bus.lifo_dout;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    count_d     = count_q + CNT_ONE;
                    out_valid_d = 1'b0;
                    state_d     = (remaining_q == CNT_ZERO) ? S_DONE : S_POP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Status flags follow the next state so they line up with it
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            short_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            short_q     <= short_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.lifo_pop  = (state_q == S_POP) && !bus.lifo_empty;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.short     = short_q;
    assign bus.count     = count_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Bench for lifo_drain_ctrl: behavioural 8-deep stack, vector table of runs,
// scoreboard of expected popped words, plus reset-during-OUT sequence.
module tb_lifo_drain_ctrl;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    lifo_drain_if #(.WIDTH(8), .CNT_W(4)) bus ();
    lifo_drain_ctrl #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    // Behavioural stack: registered read data, valid the cycle after a pop
    logic [7:0] mem [8];
    logic [3:0] sp     = 4'd0;
    logic [7:0] dout_q = 8'h00;
    logic       push_en, clr;
    logic [7:0] push_data;

    always @(posedge clk) begin
        if (clr) sp <= 4'd0;
        else if (bus.lifo_pop && sp != 4'd0) begin
            dout_q <= mem[3'(sp - 4'd1)];
            sp     <= sp - 4'd1;
        end else if (push_en && sp != 4'd8) begin
            mem[3'(sp)] <= push_data;
            sp          <= sp + 4'd1;
        end
    end
    assign bus.lifo_empty = (sp == 4'd0);
    assign bus.lifo_dout  = dout_q;

    typedef struct {
        int n_push; int base; int step; bit keep;
        int len; int stall; int pulse;
        int e_cnt; int e_short; int e_left; int e_done; int e_pops;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        @(negedge clk);
        push_en = 1'b1; push_data = v;
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic clear_stack();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic run(input vec_t v);
        int cyc, pops, done_cyc, stall_left, n_exp;
        logic [7:0] held;
        if (!v.keep) clear_stack();
        for (int i = 0; i < v.n_push; i++) push(8'(v.base + i * v.step));
        @(negedge clk);
        exp_q.delete();
        n_exp = (v.len < int'(sp)) ? v.len : int'(sp);
        for (int i = 0; i < n_exp; i++) exp_q.push_back(mem[3'(int'(sp) - 1 - i)]);
        bus.start = 1'b1; bus.len = 4'(v.len); bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; pops = 0; done_cyc = -1; stall_left = v.stall; held = 8'h00;
        while (cyc < 200) begin
            if (cyc == 1) chk("busy_rise", bus.busy, 1);
            if (bus.lifo_pop) pops++;
            if (cyc == v.pulse) begin
                bus.start = 1'b1; bus.len = 4'd15;
            end else bus.start = 1'b0;
            if (bus.out_valid && stall_left > 0) begin
                bus.out_ready = 1'b0;
                if (stall_left == v.stall) held = bus.out_data;
                else chk("stall_data", bus.out_data, held);
                chk("stall_pop", bus.lifo_pop, 0);
                chk("stall_valid", bus.out_valid, 1);
                stall_left--;
            end else bus.out_ready = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else chk("word", bus.out_data, exp_q.pop_front());
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0; bus.out_ready = 1'b1;
        chk("done_cycle", done_cyc, v.e_done);
        chk("count", bus.count, v.e_cnt);
        chk("short", bus.short, v.e_short);
        chk("pops", pops, v.e_pops);
        chk("words_left_in_sb", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done, 0);
        chk("busy_fall", bus.busy, 0);
        chk("count_hold", bus.count, v.e_cnt);
        chk("short_hold", bus.short, v.e_short);
        chk("stack_left", sp, v.e_left);
    endtask

    initial begin
        int dn;
        vec_t rv;
        //          push base  step keep len stall pulse cnt short left done pops
        tbl[0] = '{3, 'h11, 'h11, 0,  3,  0,  -1,   3,  0,    0,  10,  3};
        tbl[1] = '{1, 'hA5, 0,    0,  4,  0,  -1,   1,  1,    0,  5,   1};
        tbl[2] = '{8, 'h01, 1,    0,  2,  5,  -1,   2,  0,    6,  12,  2};
        tbl[3] = '{0, 0,    0,    0,  0,  0,  -1,   0,  0,    0,  1,   0};
        tbl[4] = '{2, 'hC1, 1,    0,  0,  0,  -1,   0,  0,    2,  1,   0};
        tbl[5] = '{0, 0,    0,    0,  1,  0,  -1,   0,  1,    0,  2,   0};
        tbl[6] = '{8, 'h01, 1,    0,  15, 0,  -1,   8,  1,    0,  26,  8};
        tbl[7] = '{5, 'h51, 1,    0,  2,  0,  4,    2,  0,    3,  7,   2};
        tbl[8] = '{8, 'h81, 3,    0,  8,  0,  -1,   8,  0,    0,  25,  8};

        rstn = 1'b0; bus.start = 1'b0; bus.len = 4'd0; bus.out_ready = 1'b1;
        push_en = 1'b0; clr = 1'b0; push_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_short", bus.short, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_pop", bus.lifo_pop, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        @(negedge clk); rstn = 1'b1;

        for (int i = 0; i < 9; i++) run(tbl[i]);

        // Reset while a word is waiting in OUT
        clear_stack();
        push(8'hA1); push(8'hA2); push(8'hA3);
        @(negedge clk);
        bus.start = 1'b1; bus.len = 4'd3; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", bus.out_valid, 1);
        @(negedge clk); rstn = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_data", bus.out_data, 0);
        @(negedge clk); rstn = 1'b1; bus.out_ready = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
        chk("post_rst_no_done", dn, 0);
        chk("post_rst_stack", sp, 2);
        rv = '{0, 0, 0, 1, 2, 0, -1, 2, 0, 0, 7, 2};
        run(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
